// File: rtl/img_pkt_ctrl.sv
// Packet controller for the image loopback path between the FT2232H RX and TX FIFOs.
// Parses OP/LEN/[PARAM], streams LEN payload bytes through a pixel operation, and frames
// each reply as SYNC, OP, payload, CHK (or SYNC, ERR, OP for an unknown opcode).
// The FIFO strobes are a registered request qualified by the live FIFO flag. This keeps
// rx_rd low whenever rx_empty is high, and tx_wr low whenever tx_full is high.
module img_pkt_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] ERR_BYTE  = 8'hEE
) (
  input  logic        clk_pll,
  input  logic        reset_n,
  input  logic [7:0]  rx_dout,
  input  logic        rx_empty,
  output logic        rx_rd,
  output logic [7:0]  tx_data,
  input  logic        tx_full,
  output logic        tx_wr,
  output logic        busy,
  output logic [15:0] pkt_count,
  output logic [7:0]  err_count
);

  localparam logic [3:0] StIdle       = 4'd0;
  localparam logic [3:0] StGetLenHi   = 4'd1;
  localparam logic [3:0] StGetLenLo   = 4'd2;
  localparam logic [3:0] StGetParam   = 4'd3;
  localparam logic [3:0] StPutSync    = 4'd4;
  localparam logic [3:0] StPutOp      = 4'd5;
  localparam logic [3:0] StPayRd      = 4'd6;
  localparam logic [3:0] StPayCap     = 4'd7;
  localparam logic [3:0] StPayWr      = 4'd8;
  localparam logic [3:0] StPutChk     = 4'd9;
  localparam logic [3:0] StPutErrSync = 4'd10;
  localparam logic [3:0] StPutErrCode = 4'd11;
  localparam logic [3:0] StPutErrOp   = 4'd12;

  logic [3:0]  state_q, state_d;
  logic        pend_q, pend_d;      // header byte requested, capture at end of this cycle
  logic        rd_req_q, rd_req_d;
  logic        wr_req_q, wr_req_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  param_q, param_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        busy_q, busy_d;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic [7:0]  err_count_q, err_count_d;

  logic       rd_fire;
  logic       wr_fire;
  logic [7:0] pix;

  assign rd_fire   = rd_req_q & ~rx_empty;
  assign wr_fire   = wr_req_q & ~tx_full;
  assign rx_rd     = rd_fire;
  assign tx_wr     = wr_fire;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;

  // Pixel operation applied to the byte being captured.
  always_comb begin
    pix = rx_dout;
    case (op_q)
      8'h02:   pix = ~rx_dout;
      8'h03:   pix = (rx_dout >= param_q) ? 8'hFF : 8'h00;
      default: pix = rx_dout;
    endcase
  end

  // Next-state, datapath loads and strobe requests for the following cycle.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    op_d        = op_q;
    len_d       = len_q;
    param_d     = param_q;
    chk_d       = chk_q;
    tx_data_d   = tx_data_q;
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;

    unique case (state_q)
      StIdle, StGetLenHi, StGetLenLo, StGetParam: begin
        if (pend_q) begin
          pend_d = 1'b0;
          unique case (state_q)
            StIdle: begin
              op_d = rx_dout;
              if (rx_dout == 8'h01 || rx_dout == 8'h02 || rx_dout == 8'h03) begin
                state_d = StGetLenHi;
              end else begin
                state_d   = StPutErrSync;
                tx_data_d = SYNC_BYTE;
              end
            end
            StGetLenHi: begin
              len_d   = {rx_dout, len_q[7:0]};
              state_d = StGetLenLo;
            end
            StGetLenLo: begin
              len_d = {len_q[15:8], rx_dout};
              if (op_q == 8'h03) begin
                state_d = StGetParam;
              end else begin
                state_d   = StPutSync;
                tx_data_d = SYNC_BYTE;
              end
            end
            default: begin
              param_d   = rx_dout;
              state_d   = StPutSync;
              tx_data_d = SYNC_BYTE;
            end
          endcase
        end else if (rd_fire) begin
          pend_d = 1'b1;
        end
      end
      StPutSync: begin
        chk_d = 8'h00;
        if (wr_fire) begin
          state_d   = StPutOp;
          tx_data_d = op_q;
        end
      end
      StPutOp: begin
        if (wr_fire) begin
          if (len_q != 16'd0) begin
            state_d = StPayRd;
          end else begin
            state_d   = StPutChk;
            tx_data_d = chk_q;
          end
        end
      end
      StPayRd: begin
        if (rd_fire) state_d = StPayCap;
      end
      StPayCap: begin
        tx_data_d = pix;
        chk_d     = chk_q + pix;
        state_d   = StPayWr;
      end
      StPayWr: begin
        if (wr_fire) begin
          len_d = len_q - 16'd1;
          if (len_q == 16'd1) begin
            state_d   = StPutChk;
            tx_data_d = chk_q;
          end else begin
            state_d = StPayRd;
          end
        end
      end
      StPutChk: begin
        if (wr_fire) begin
          pkt_count_d = pkt_count_q + 16'd1;
          state_d     = StIdle;
        end
      end
      StPutErrSync: begin
        if (wr_fire) begin
          state_d   = StPutErrCode;
          tx_data_d = ERR_BYTE;
        end
      end
      StPutErrCode: begin
        if (wr_fire) begin
          state_d   = StPutErrOp;
          tx_data_d = op_q;
        end
      end
      StPutErrOp: begin
        if (wr_fire) begin
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        pend_d  = 1'b0;
      end
    endcase

    rd_req_d = 1'b0;
    wr_req_d = 1'b0;
    case (state_d)
      StIdle, StGetLenHi, StGetLenLo, StGetParam: rd_req_d = ~pend_d;
      StPayRd:                                    rd_req_d = 1'b1;
      StPutSync, StPutOp, StPayWr, StPutChk,
      StPutErrSync, StPutErrCode, StPutErrOp:     wr_req_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk_pll or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      pend_q      <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      op_q        <= 8'h00;
      len_q       <= 16'h0000;
      param_q     <= 8'h00;
      chk_q       <= 8'h00;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      pkt_count_q <= 16'h0000;
      err_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      op_q        <= op_d;
      len_q       <= len_d;
      param_q     <= param_d;
      chk_q       <= chk_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
    end
  end

endmodule
